spi_target_byte_port: RTL and testbench

Single-lane SPI target (slave) port. It samples an external host's SCK, CS_n and MOSI with the system clock and presents received bytes on a valid/ready stream. It drives MISO from a one-entry transmit holding register. It sits behind the pad mux on the same pins the on-chip SPI master uses when the SoC is the initiator, and runs in SPI mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/spi_target_byte_port.sv | 182 ++++++++++++++++++
 tb/tb_spi_target_byte_port.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_byte_port.sv
// SPI mode-0 target port: pins sampled on clk, received bytes on a valid/ready
// stream, MISO driven from a one-entry transmit holding register.
module spi_target_byte_port #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       frame_active,
    output logic       frame_end,
    output logic       rx_overrun,
    output logic       tx_underrun,
    input  logic       status_clr
);

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_hist_q, sck_hist_d;
    logic                   cs_hist_q, cs_hist_d;

    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_full_q, tx_full_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       byte_done_q, byte_done_d;
    logic       miso_oe_q, miso_oe_d;
    logic       frame_end_q, frame_end_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_underrun_q, tx_underrun_d;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, cs_fall, cs_rise, active;
    logic [7:0] rx_byte;
    logic       tx_load;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_hist_q;
    assign sck_fall = ~sck_s & sck_hist_q;
    assign cs_fall  = ~cs_s & cs_hist_q;
    assign cs_rise  = cs_s & ~cs_hist_q;
    assign active   = ~cs_s;
    assign rx_byte  = {rx_shift_q[6:0], mosi_s};

    always_comb begin
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        sck_hist_d    = sck_s;
        cs_hist_d     = cs_s;

        rx_shift_d    = rx_shift_q;
        bit_cnt_d     = bit_cnt_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q & ~rx_ready;
        tx_hold_d     = tx_hold_q;
        tx_full_d     = tx_full_q;
        tx_shift_d    = tx_shift_q;
        byte_done_d   = byte_done_q;
        miso_oe_d     = miso_oe_q;
        frame_end_d   = cs_rise;
        rx_overrun_d  = rx_overrun_q & ~status_clr;
        tx_underrun_d = tx_underrun_q & ~status_clr;
        tx_load       = 1'b0;

        if (cs_fall) begin
            bit_cnt_d   = '0;
            miso_oe_d   = 1'b1;
            byte_done_d = 1'b0;
            tx_load     = 1'b1;
        end else if (cs_rise) begin
            // partial rx byte is simply abandoned; bit_cnt restart discards it
            bit_cnt_d   = '0;
            miso_oe_d   = 1'b0;
            byte_done_d = 1'b0;
        end else if (active) begin
            if (sck_rise) begin
                rx_shift_d  = rx_byte;
                bit_cnt_d   = bit_cnt_q + 3'd1;
                byte_done_d = (bit_cnt_q == 3'd7);
                if (bit_cnt_q == 3'd7) begin
                    if (!rx_valid_q || rx_ready) begin
                        rx_data_d  = rx_byte;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_overrun_d = 1'b1;
                    end
                end
            end else if (sck_fall) begin
                if (byte_done_q) begin
                    tx_load     = 1'b1;
                    byte_done_d = 1'b0;
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b0};
                end
            end
        end

        if (tx_load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_hold_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d    = DEFAULT_TX;
                tx_underrun_d = 1'b1;
            end
        end

        // acceptance only happens while empty, so it never collides with a drain
        if (tx_valid && !tx_full_q) begin
            tx_hold_d = tx_data;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q    <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sck_hist_q    <= 1'b0;
            cs_hist_q     <= 1'b1;
            rx_shift_q    <= '0;
            bit_cnt_q     <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_hold_q     <= '0;
            tx_full_q     <= 1'b0;
            tx_shift_q    <= DEFAULT_TX;
            byte_done_q   <= 1'b0;
            miso_oe_q     <= 1'b0;
            frame_end_q   <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sck_hist_q    <= sck_hist_d;
            cs_hist_q     <= cs_hist_d;
            rx_shift_q    <= rx_shift_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_hold_q     <= tx_hold_d;
            tx_full_q     <= tx_full_d;
            tx_shift_q    <= tx_shift_d;
            byte_done_q   <= byte_done_d;
            miso_oe_q     <= miso_oe_d;
            frame_end_q   <= frame_end_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign spi_miso_o   = tx_shift_q[7];
    assign spi_miso_oe  = miso_oe_q;
    assign rx_valid     = rx_valid_q;
    assign rx_data      = rx_data_q;
    assign tx_ready     = ~tx_full_q;
    assign frame_active = active;
    assign frame_end    = frame_end_q;
    assign rx_overrun   = rx_overrun_q;
    assign tx_underrun  = tx_underrun_q;

endmodule

// File: tb/tb_spi_target_byte_port.sv
// Directed bench for spi_target_byte_port: a mode-0 host model drives the pins
// and received/sent bytes are compared against hand-computed values.
module tb_spi_target_byte_port;

    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [7:0]  DEF_TX      = 8'hFF;
    localparam int          H           = 8;

    logic       clk;
    logic       rst_n;
    logic       spi_sck_i, spi_cs_n_i, spi_mosi_i;
    logic       spi_miso_o, spi_miso_oe;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic       frame_active, frame_end, rx_overrun, tx_underrun, status_clr;

    spi_target_byte_port #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEFAULT_TX (DEF_TX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck_i   (spi_sck_i),
        .spi_cs_n_i  (spi_cs_n_i),
        .spi_mosi_i  (spi_mosi_i),
        .spi_miso_o  (spi_miso_o),
        .spi_miso_oe (spi_miso_oe),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .frame_active(frame_active),
        .frame_end   (frame_end),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .status_clr  (status_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_log [16];
    int         rx_n;
    int         valid_cycles;
    int         fe_cnt;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            if (rx_n < 16) rx_log[rx_n] = rx_data;
            rx_n++;
        end
        if (rx_valid) valid_cycles++;
        if (frame_end) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rx_n = 0;
        valid_cycles = 0;
        fe_cnt = 0;
        for (int i = 0; i < 16; i++) rx_log[i] = 'x;
    endtask

    // Host side of one byte, MSB first; optionally raises rx_ready only in the
    // cycle where the 8th rise is seen by the DUT.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit rdy_pulse,
                            output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = mo[7-i];
            tick(H);
            mi[7-i] = spi_miso_o;
            spi_sck_i = 1'b1;
            if (rdy_pulse && i == 7) begin
                tick(SYNC_STAGES);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                tick(H - SYNC_STAGES - 1);
            end else begin
                tick(H);
            end
            spi_sck_i = 1'b0;
        end
    endtask

    task automatic cs_start();
        spi_cs_n_i = 1'b0;
        tick(H);
    endtask

    task automatic cs_stop();
        tick(H);
        spi_cs_n_i = 1'b1;
        tick(H);
    endtask

    task automatic pulse_clr();
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] m0, m1, m2;

    initial begin
        rst_n = 1'b0;
        spi_sck_i = 1'b0; spi_cs_n_i = 1'b1; spi_mosi_i = 1'b0;
        rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0; status_clr = 1'b0;
        clear_log();
        tick(2);
        for (int i = 0; i < 4; i++) begin
            spi_cs_n_i = ~spi_cs_n_i;
            spi_sck_i  = ~spi_sck_i;
            tick(3);
        end
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_miso_oe", spi_miso_oe, 0);
        chk("rst_miso", spi_miso_o, DEF_TX[7]);
        chk("rst_frame_active", frame_active, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_underrun", tx_underrun, 0);

        rst_n = 1'b1;
        tick(5);
        for (int i = 0; i < 8; i++) begin
            spi_sck_i = ~spi_sck_i;
            tick(H);
        end
        chk("idle_frame_active", frame_active, 0);
        chk("idle_miso_oe", spi_miso_oe, 0);
        chk("idle_rx_valid_cycles", valid_cycles, 0);
        chk("idle_frame_end", fe_cnt, 0);
        chk("idle_tx_ready", tx_ready, 1);

        // RX with preloaded TX byte
        tx_valid = 1'b1; tx_data = 8'hA5;
        tick(1);
        tx_valid = 1'b0;
        chk("pre_tx_ready", tx_ready, 0);
        rx_ready = 1'b1;
        clear_log();
        cs_start();
        chk("f1_miso_oe", spi_miso_oe, 1);
        chk("f1_frame_active", frame_active, 1);
        chk("f1_tx_ready", tx_ready, 1);
        chk("f1_underrun_start", tx_underrun, 0);
        spi_bits(8'h3C, 8, 1'b0, m0);
        spi_bits(8'hC3, 8, 1'b0, m1);
        cs_stop();
        chk("f1_miso_b0", m0, 8'hA5);
        chk("f1_miso_b1", m1, 8'hFF);
        chk("f1_rx_count", rx_n, 2);
        chk("f1_rx_b0", rx_log[0], 8'h3C);
        chk("f1_rx_b1", rx_log[1], 8'hC3);
        chk("f1_valid_cycles", valid_cycles, 2);
        chk("f1_rx_data", rx_data, 8'hC3);
        chk("f1_underrun", tx_underrun, 1);
        chk("f1_frame_end", fe_cnt, 1);
        chk("f1_miso_oe_end", spi_miso_oe, 0);

        // Overrun
        rx_ready = 1'b0;
        cs_start();
        spi_bits(8'h11, 8, 1'b0, m0);
        spi_bits(8'h22, 8, 1'b0, m1);
        cs_stop();
        chk("ovr_rx_valid", rx_valid, 1);
        chk("ovr_rx_data", rx_data, 8'h11);
        chk("ovr_flag", rx_overrun, 1);
        pulse_clr();
        chk("ovr_clr", rx_overrun, 0);
        chk("ovr_clr_underrun", tx_underrun, 0);

        // Accept in the same cycle the second byte completes
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("sim_drained", rx_valid, 0);
        clear_log();
        cs_start();
        spi_bits(8'h55, 8, 1'b0, m0);
        spi_bits(8'hAA, 8, 1'b1, m1);
        cs_stop();
        chk("sim_rx_valid", rx_valid, 1);
        chk("sim_rx_data", rx_data, 8'hAA);
        chk("sim_overrun", rx_overrun, 0);
        chk("sim_xfer_count", rx_n, 1);
        chk("sim_xfer_b0", rx_log[0], 8'h55);
        rx_ready = 1'b1;
        tick(1);

        // Mid-byte abort, then a clean frame
        clear_log();
        cs_start();
        spi_bits(8'hF0, 5, 1'b0, m0);
        cs_stop();
        chk("abort_frame_end", fe_cnt, 1);
        chk("abort_valid_cycles", valid_cycles, 0);
        chk("abort_miso_oe", spi_miso_oe, 0);
        chk("abort_overrun", rx_overrun, 0);
        cs_start();
        spi_bits(8'h7E, 8, 1'b0, m0);
        cs_stop();
        chk("after_abort_count", rx_n, 1);
        chk("after_abort_b0", rx_log[0], 8'h7E);

        // TX back-to-back with a producer refilling on tx_ready
        pulse_clr();
        chk("b2b_underrun_pre", tx_underrun, 0);
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    int n;
                    n = 0;
                    while (!tx_ready && n < 400) begin
                        tick(1);
                        n++;
                    end
                    chk("b2b_prod_ready", tx_ready, 1);
                    tx_valid = 1'b1;
                    tx_data  = 8'(k);
                    tick(1);
                    tx_valid = 1'b0;
                end
            end
            begin
                tick(4);
                cs_start();
                spi_bits(8'h00, 8, 1'b0, m0);
                spi_bits(8'h00, 8, 1'b0, m1);
                spi_bits(8'h00, 8, 1'b0, m2);
                cs_stop();
            end
        join
        chk("b2b_miso_b0", m0, 8'h01);
        chk("b2b_miso_b1", m1, 8'h02);
        chk("b2b_miso_b2", m2, 8'h03);
        chk("b2b_underrun", tx_underrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
